// File: rtl/fsk_pkg.sv
// Shared types and helpers for the FSK modulator: symbol FSM states and tone half-period math.
// Counter width is sized to hold a full symbol length at any practical clock rate.
package fsk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsk_state_t;

    localparam int unsigned CNT_W = 32;

    function automatic int unsigned half_period_ticks(input int unsigned clock_hz,
                                                      input int unsigned tone_hz);
        return clock_hz / (2 * tone_hz);
    endfunction

endpackage

// File: rtl/fsk_half_period_counter.sv
// Half-period timer: strobes o_toggle on the cycle the count reaches i_half-1, then wraps.
// Latency: first strobe i_half enabled cycles after i_load; i_load wins over a coincident strobe.
module fsk_half_period_counter
    import fsk_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic [CNT_W-1:0] i_half,
    input  logic             i_load,
    input  logic             i_en,
    output logic             o_toggle
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap   = (r_cnt == i_half - CNT_W'(1));
    assign o_toggle = i_en && !i_load && w_wrap;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fsk_modulator.sv
// Square-wave FSK of a valid/ready bit stream, one symbol per BIT_TICKS cycles; bit_ready is combinational.
// Back-to-back symbols need no idle cycle; enable=0 freezes everything. FSK_MODULATOR_STATS_EN adds tone-cycle counters.
module fsk_modulator
    import fsk_pkg::*;
#(
    parameter int unsigned FREQUENCY0      = 9000,
    parameter int unsigned FREQUENCY1      = 11000,
    parameter int unsigned BIT_RATE        = 1000,
    parameter int unsigned CLOCK_FREQUENCY = 50000000
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_data,
    input  logic        bit_valid,
    output logic        bit_ready,
    output logic        fsk_out,
    output logic        busy,
    output logic [31:0] f0_ticks,
    output logic [31:0] f1_ticks
);

    localparam int unsigned HALF0     = half_period_ticks(CLOCK_FREQUENCY, FREQUENCY0);
    localparam int unsigned HALF1     = half_period_ticks(CLOCK_FREQUENCY, FREQUENCY1);
    localparam int unsigned BIT_TICKS = CLOCK_FREQUENCY / BIT_RATE;

    localparam logic [CNT_W-1:0] HALF0_W  = CNT_W'(HALF0);
    localparam logic [CNT_W-1:0] HALF1_W  = CNT_W'(HALF1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_TICKS - 1);

    generate
        if (FREQUENCY1 <= FREQUENCY0) begin : g_bad_freq
            $fatal(1, "fsk_modulator: FREQUENCY1 must be greater than FREQUENCY0");
        end
        if (HALF1 < 2) begin : g_bad_half1
            $fatal(1, "fsk_modulator: HALF1 must be at least 2 clock cycles");
        end
        if (BIT_TICKS < 2 * HALF0) begin : g_bad_bit
            $fatal(1, "fsk_modulator: a symbol must span at least one full FREQUENCY0 period");
        end
    endgenerate

    fsk_state_t       r_state;
    fsk_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_cur_bit;
    logic             r_fsk;
    logic             w_bit_end;
    logic             w_run;
    logic             w_accept;
    logic             w_toggle;
    logic [CNT_W-1:0] w_half;

    assign w_bit_end = (r_bit_cnt == BIT_LAST);
    assign w_run     = enable && (r_state == SEND);
    assign w_accept  = bit_valid && bit_ready;
    assign w_half    = r_cur_bit ? HALF1_W : HALF0_W;
    assign fsk_out   = r_fsk;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (enable) begin
            case (r_state)
                IDLE:    if (bit_valid) w_state_nxt = SEND;
                SEND:    if (w_bit_end) w_state_nxt = bit_valid ? SEND : IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state == SEND);
        bit_ready = enable && ((r_state == IDLE) || w_bit_end);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_bit_cnt <= '0;
            r_cur_bit <= 1'b0;
        end else if (w_accept) begin
            r_bit_cnt <= '0;
            r_cur_bit <= bit_data;
        end else if (w_run) begin
            r_bit_cnt <= w_bit_end ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

    // The output level carries across symbols and idle; only a half-period strobe may flip it.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_fsk <= 1'b0;
        end else if (w_toggle) begin
            r_fsk <= ~r_fsk;
        end
    end

    fsk_half_period_counter u_half (
        .clock    (clock),
        .clear    (clear),
        .i_half   (w_half),
        .i_load   (w_accept),
        .i_en     (w_run),
        .o_toggle (w_toggle)
    );

`ifdef FSK_MODULATOR_STATS_EN
    logic [31:0] r_f0_ticks;
    logic [31:0] r_f1_ticks;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_f0_ticks <= '0;
            r_f1_ticks <= '0;
        end else if (w_run) begin
            if (!r_cur_bit && (r_f0_ticks != '1)) r_f0_ticks <= r_f0_ticks + 32'd1;
            if (r_cur_bit && (r_f1_ticks != '1))  r_f1_ticks <= r_f1_ticks + 32'd1;
        end
    end

    assign f0_ticks = r_f0_ticks;
    assign f1_ticks = r_f1_ticks;
`else
    assign f0_ticks = '0;
    assign f1_ticks = '0;
`endif

endmodule

// File: tb/tb_fsk_modulator.sv
// Randomized scoreboard bench for fsk_modulator; timing is modelled in "enabled clock edges" so pauses are transparent.
// Small parameters: HALF0=12, HALF1=7, BIT_TICKS=40 (neither half divides the symbol length).
module tb_fsk_modulator;

    localparam int unsigned CF = 1200;
    localparam int unsigned F0 = 50;
    localparam int unsigned F1 = 80;
    localparam int unsigned BR = 30;
    localparam int H0    = CF / (2 * F0);
    localparam int H1    = CF / (2 * F1);
    localparam int BT    = CF / BR;
    localparam int N_SYM = 16;

    logic        clock     = 1'b0;
    logic        clear     = 1'b1;
    logic        enable    = 1'b0;
    logic        bit_data  = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_ready;
    logic        fsk_out;
    logic        busy;
    logic [31:0] f0_ticks;
    logic [31:0] f1_ticks;

    int n_cmp = 0;
    int n_bad = 0;
    int et = 0;
    int acc_seen = 0;
    int cur_end = 0;
    bit mon_on = 1'b0;
    bit prev_fsk = 1'b0;
    bit prev_busy = 1'b0;
    int edge_q[$];
    int acc_et_q[$];
    bit acc_bit_q[$];

    int  prev_acc;
    int  acc;
    int  n0;
    int  n1;
    int  gap;
    int  waited;
    int  start_cnt;
    int  pause_left = 0;
    bit  allow_pause = 1'b0;
    bit  b;

    always #5 clock = ~clock;

    fsk_modulator #(
        .FREQUENCY0      (F0),
        .FREQUENCY1      (F1),
        .BIT_RATE        (BR),
        .CLOCK_FREQUENCY (CF)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .enable    (enable),
        .bit_data  (bit_data),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .fsk_out   (fsk_out),
        .busy      (busy),
        .f0_ticks  (f0_ticks),
        .f1_ticks  (f1_ticks)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Outputs sampled at negedge; the handshake and enable are sampled 1 time unit before each posedge.
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (mon_on) begin
                if (fsk_out !== prev_fsk) begin
                    if (edge_q.size() == 0) check("spurious_fsk_edge_et", et, -1);
                    else                    check("fsk_edge_et", et, edge_q.pop_front());
                end
                if (prev_busy && !busy) check("busy_fall_et", et, cur_end);
            end
            prev_fsk  = fsk_out;
            prev_busy = busy;
            #4;
            if (mon_on && clear) begin
                if (!enable) begin
                    check("bit_ready_while_disabled", bit_ready, 0);
                end else begin
                    et++;
                    if (bit_valid && bit_ready) begin
                        acc_seen++;
                        if (acc_et_q.size() == 0) begin
                            check("unexpected_accept_et", et, -1);
                        end else begin
                            check("accept_et", et, acc_et_q.pop_front());
                            check("accept_bit", bit_data, acc_bit_q.pop_front());
                        end
                        cur_end = et + BT;
                    end
                end
            end
        end
    end

    task automatic step_cycle();
        @(negedge clock);
        #1;
        if (pause_left > 0) begin
            enable = 1'b0;
            pause_left--;
        end else begin
            enable = 1'b1;
            if (allow_pause && ($urandom_range(0, 29) == 0)) pause_left = $urandom_range(1, 20);
        end
    endtask

    initial begin : driver
        #1 clear = 1'b0;
        enable = 1'b1;
        #1;
        check("rst_fsk_out", fsk_out, 0);
        check("rst_busy", busy, 0);
        check("rst_f0_ticks", f0_ticks, 0);
        check("rst_f1_ticks", f1_ticks, 0);

        // Valid offered while disabled straight out of reset must never be taken.
        repeat (3) @(negedge clock);
        #1;
        enable    = 1'b0;
        bit_data  = 1'b1;
        bit_valid = 1'b1;
        clear     = 1'b1;
        mon_on    = 1'b1;
        repeat (100) @(negedge clock);
        #1;
        check("disabled_busy", busy, 0);
        check("disabled_fsk_out", fsk_out, 0);
        bit_valid = 1'b0;
        enable    = 1'b1;

        prev_acc    = -1000;
        n0          = 0;
        n1          = 0;
        allow_pause = 1'b1;
        for (int s = 0; s < N_SYM; s++) begin
            gap = ($urandom_range(0, 2) == 0 || s == 1) ? 0 : $urandom_range(1, 25);
            if (gap > 0) begin
                bit_valid = 1'b0;
                repeat (gap) step_cycle();
            end
            b = (s < 2) ? s[0] : 1'($urandom_range(0, 1));
            bit_data  = b;
            bit_valid = 1'b1;
            acc = (et + 1 > prev_acc + BT) ? et + 1 : prev_acc + BT;
            acc_et_q.push_back(acc);
            acc_bit_q.push_back(b);
            for (int k = 1; k * (b ? H1 : H0) < BT; k++) edge_q.push_back(acc + k * (b ? H1 : H0));
            prev_acc = acc;
            if (b) n1++;
            else   n0++;
            start_cnt = acc_seen;
            waited    = 0;
            while (acc_seen == start_cnt && waited < 400) begin
                step_cycle();
                waited++;
            end
            if (acc_seen == start_cnt) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: symbol %0d not taken after %0d cycles, expected by enabled edge %0d", s, waited, acc);
                break;
            end
        end

        bit_valid   = 1'b0;
        allow_pause = 1'b0;
        pause_left  = 0;
        waited      = 0;
        while (busy && waited < 200) begin
            step_cycle();
            waited++;
        end
        repeat (5) step_cycle();
        check("drain_busy", busy, 0);
        check("edges_outstanding", edge_q.size(), 0);
        check("accepts_outstanding", acc_et_q.size(), 0);
`ifdef FSK_MODULATOR_STATS_EN
        check("f0_ticks", f0_ticks, n0 * BT);
        check("f1_ticks", f1_ticks, n1 * BT);
`else
        check("f0_ticks", f0_ticks, 0);
        check("f1_ticks", f1_ticks, 0);
`endif

        // Asynchronous clear in the middle of a bit-0 symbol while the output is high.
        mon_on    = 1'b0;
        bit_data  = 1'b0;
        bit_valid = 1'b1;
        step_cycle();
        bit_valid = 1'b0;
        waited    = 0;
        while (fsk_out !== 1'b1 && waited < 2 * H0 + 2) begin
            step_cycle();
            waited++;
        end
        check("pre_reset_fsk_out", fsk_out, 1);
        check("pre_reset_busy", busy, 1);
        #2;
        clear = 1'b0;
        #1;
        check("async_rst_fsk_out", fsk_out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_f0_ticks", f0_ticks, 0);
        check("async_rst_f1_ticks", f1_ticks, 0);
        @(negedge clock);
        #1;
        clear  = 1'b1;
        enable = 1'b1;
        #1;
        check("post_rst_bit_ready", bit_ready, 1);
        check("post_rst_busy", busy, 0);
        repeat (2 * BT) step_cycle();
        check("no_resume_busy", busy, 0);
        check("no_resume_fsk_out", fsk_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
